// File: rtl/sd_cmd_sequencer_if.sv
// sd_cmd_sequencer_if: groups the command, FIFO, SPI-master and response signals of the
// SD command sequencer.
//   master modport: the sequencer (drives cmd_ready, FIFO strobes, SPI controls, response)
//   slave modport : the surrounding system (controller, byte FIFO, SPI master)
//   cmd_*          : command request handshake and payload
//   fifo_*         : shared byte FIFO write/read port
//   spi_*          : SPI master start/length/status
//   resp_*, done, timeout_err : completed-command results
interface sd_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [2:0]  cmd_resp_len;

  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;

  logic        spi_start;
  logic [5:0]  spi_cmd_length;
  logic [5:0]  spi_response_length;
  logic        spi_busy;
  logic        spi_valid;

  logic [7:0]  resp_r1;
  logic [31:0] resp_ext;
  logic        done;
  logic        timeout_err;

  modport master (
    input  cmd_valid, cmd_index, cmd_arg, cmd_resp_len,
    input  fifo_rd_data, spi_busy, spi_valid,
    output cmd_ready, fifo_wr_en, fifo_wr_data, fifo_rd_en,
    output spi_start, spi_cmd_length, spi_response_length,
    output resp_r1, resp_ext, done, timeout_err
  );

  modport slave (
    output cmd_valid, cmd_index, cmd_arg, cmd_resp_len,
    output fifo_rd_data, spi_busy, spi_valid,
    input  cmd_ready, fifo_wr_en, fifo_wr_data, fifo_rd_en,
    input  spi_start, spi_cmd_length, spi_response_length,
    input  resp_r1, resp_ext, done, timeout_err
  );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: upstream command stage for the SD-card SPI master.
// Accepts a command (index, 32-bit argument, response length), writes the 6-byte SD SPI
// frame with CRC7 into the shared byte FIFO, starts the SPI master, waits for completion
// (with timeout), then pops the response bytes and presents R1 plus up to 4 extension bytes.
// Ports:
//   i_clk  : system clock
//   i_rst  : synchronous active-high reset
//   io_bus : sd_cmd_sequencer_if.master (command, FIFO, SPI and response signals)
module sd_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TS_WIDTH       = 20
) (
  input logic                i_clk,
  input logic                i_rst,
  sd_cmd_sequencer_if.master io_bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWait,
    StDrain,
    StDone
  } state_e;

  localparam logic [TS_WIDTH-1:0] TsLast = TS_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e r_state;
  state_e w_state_next;

  logic                r_rdy_en;  // keeps cmd_ready low for the first cycle after reset
  logic [5:0]          r_index;
  logic [31:0]         r_arg;
  logic [2:0]          r_len;
  logic [2:0]          r_k;       // frame byte index in LOAD, capture index in DRAIN
  logic [6:0]          r_crc;
  logic [TS_WIDTH-1:0] r_tcnt;
  logic                r_phase;   // DRAIN: 0 = issue rd_en, 1 = capture byte
  logic [7:0]          r_r1;
  logic [31:0]         r_ext;
  logic                r_timeout;

  logic                w_accept;
  logic                w_tlast;
  logic [7:0]          w_byte;
  logic                w_cmd_ready;
  logic                w_wr_en;
  logic                w_rd_en;
  logic                w_start;
  logic                w_done;

  // CRC7 (x^7 + x^3 + 1), MSB first, one whole byte per call.
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign w_accept = (r_state == StIdle) && r_rdy_en && io_bus.cmd_valid;
  assign w_tlast  = (r_tcnt == TsLast);

  // Frame byte for the current LOAD index; the last byte carries the accumulated CRC.
  always_comb begin
    w_byte = 8'h00;
    unique case (r_k)
      3'd0:    w_byte = {2'b01, r_index};
      3'd1:    w_byte = r_arg[31:24];
      3'd2:    w_byte = r_arg[23:16];
      3'd3:    w_byte = r_arg[15:8];
      3'd4:    w_byte = r_arg[7:0];
      3'd5:    w_byte = {r_crc, 1'b1};
      default: w_byte = 8'h00;
    endcase
  end

  // Next-state and decoded outputs.
  always_comb begin
    w_state_next = r_state;
    w_cmd_ready  = 1'b0;
    w_wr_en      = 1'b0;
    w_rd_en      = 1'b0;
    w_start      = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cmd_ready = r_rdy_en;
        if (w_accept) w_state_next = StLoad;
      end
      StLoad: begin
        w_wr_en = 1'b1;
        if (r_k == 3'd5) w_state_next = StStart;
      end
      StStart: begin
        // Held high until the master reports busy; it only samples start on its SCK tick.
        w_start = 1'b1;
        if (io_bus.spi_busy) w_state_next = StWait;
        else if (w_tlast)    w_state_next = StDone;
      end
      StWait: begin
        // spi_valid takes priority over a coincident timeout.
        if (io_bus.spi_valid) w_state_next = (r_len == 3'd0) ? StDone : StDrain;
        else if (w_tlast)     w_state_next = StDone;
      end
      StDrain: begin
        w_rd_en = ~r_phase;
        if (r_phase && (r_k == r_len - 3'd1)) w_state_next = StDone;
      end
      StDone: begin
        w_done       = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  // Datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdy_en  <= 1'b0;
      r_index   <= '0;
      r_arg     <= '0;
      r_len     <= '0;
      r_k       <= '0;
      r_crc     <= '0;
      r_tcnt    <= '0;
      r_phase   <= 1'b0;
      r_r1      <= 8'hFF;
      r_ext     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_index   <= io_bus.cmd_index;
            r_arg     <= io_bus.cmd_arg;
            r_len     <= (io_bus.cmd_resp_len > 3'd5) ? 3'd5 : io_bus.cmd_resp_len;
            r_r1      <= 8'hFF;
            r_ext     <= '0;
            r_k       <= '0;
            r_crc     <= '0;
            r_timeout <= 1'b0;
          end
        end
        StLoad: begin
          if (r_k != 3'd5) r_crc <= crc7_byte(r_crc, w_byte);
          r_k    <= r_k + 3'd1;
          r_tcnt <= '0;
        end
        StStart: begin
          if (io_bus.spi_busy) r_tcnt    <= '0;
          else if (w_tlast)    r_timeout <= 1'b1;
          else                 r_tcnt    <= r_tcnt + 1'b1;
        end
        StWait: begin
          if (io_bus.spi_valid) begin
            r_k     <= '0;
            r_phase <= 1'b0;
          end else if (w_tlast) begin
            r_timeout <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        StDrain: begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            // Byte j of the response lands in resp_ext[39-8j -: 8]; byte 0 is R1.
            unique case (r_k)
              3'd0:    r_r1          <= io_bus.fifo_rd_data;
              3'd1:    r_ext[31:24]  <= io_bus.fifo_rd_data;
              3'd2:    r_ext[23:16]  <= io_bus.fifo_rd_data;
              3'd3:    r_ext[15:8]   <= io_bus.fifo_rd_data;
              3'd4:    r_ext[7:0]    <= io_bus.fifo_rd_data;
              default: ;
            endcase
            r_k <= r_k + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.cmd_ready           = w_cmd_ready;
  assign io_bus.fifo_wr_en          = w_wr_en;
  assign io_bus.fifo_wr_data        = w_wr_en ? w_byte : 8'h00;
  assign io_bus.fifo_rd_en          = w_rd_en;
  assign io_bus.spi_start           = w_start;
  assign io_bus.spi_cmd_length      = (r_state != StIdle) ? 6'd6 : 6'd0;
  assign io_bus.spi_response_length = (r_state != StIdle) ? {3'b000, r_len} : 6'd0;
  assign io_bus.resp_r1             = r_r1;
  assign io_bus.resp_ext            = r_ext;
  assign io_bus.done                = w_done;
  assign io_bus.timeout_err         = r_timeout;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed testbench for sd_cmd_sequencer with a small SPI-master / FIFO model.
module tb_sd_cmd_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  sd_cmd_sequencer_if bus ();

  sd_cmd_sequencer #(
    .TIMEOUT_CYCLES(50),
    .TS_WIDTH      (20)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  // Observations of the last command run through run_cmd.
  logic [7:0]  wr_bytes [0:7];
  int          nwr, first_wr, last_wr, start_cnt, start_late, start_cyc;
  int          rd_cnt, done_cnt, done_cyc, valid_cyc, busy_cyc;
  logic        done_to, done_after, ready_after, to_after;
  logic [7:0]  r1_at_done;
  logic [31:0] ext_at_done;
  logic [5:0]  cmdlen_seen, resplen_seen;

  // Issues one command and models the SPI master / FIFO. busy_delay: number of cycles
  // spi_start is seen before busy rises (large = never). valid_delay: cycles of busy before
  // the spi_valid pulse (negative = never). resp: response bytes, byte 0 in [39:32].
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [2:0] len,
                         input int busy_delay, input int valid_delay, input logic [39:0] resp);
    int cyc, busy_age, rd_idx;
    bit busy_drv, fin, acc;
    nwr = 0; first_wr = -1; last_wr = -1; start_cnt = 0; start_late = 0; start_cyc = -1;
    rd_cnt = 0; done_cnt = 0; done_cyc = -1; valid_cyc = -1; busy_cyc = -1;
    done_to = 1'bx; done_after = 1'bx; ready_after = 1'bx; to_after = 1'bx;
    r1_at_done = 8'hxx; ext_at_done = 'x; cmdlen_seen = 'x; resplen_seen = 'x;
    for (int i = 0; i < 8; i++) wr_bytes[i] = 8'hxx;
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) acc = 1;
    end
    if (!acc) return;
    bus.cmd_valid = 1'b1; bus.cmd_index = idx; bus.cmd_arg = arg; bus.cmd_resp_len = len;
    cyc = 0; busy_age = 0; rd_idx = 0; busy_drv = 0; fin = 0;
    for (int i = 0; i < 300 && !fin; i++) begin
      @(negedge clk);
      cyc++;
      bus.cmd_valid = 1'b0;
      if (done_cnt > 0) begin
        done_after = bus.done; ready_after = bus.cmd_ready; to_after = bus.timeout_err;
        fin = 1;
      end else begin
        if (bus.fifo_wr_en === 1'b1) begin
          if (nwr < 8) wr_bytes[nwr] = bus.fifo_wr_data;
          if (nwr == 0) begin
            first_wr = cyc; cmdlen_seen = bus.spi_cmd_length;
            resplen_seen = bus.spi_response_length;
          end
          last_wr = cyc;
          nwr++;
        end
        if (bus.spi_start === 1'b1) begin
          start_cnt++;
          if (start_cyc < 0) start_cyc = cyc;
          if (busy_drv) start_late++;
        end
        if (bus.fifo_rd_en === 1'b1) begin
          rd_cnt++;
          if (rd_idx < 5) bus.fifo_rd_data = resp[39-8*rd_idx -: 8];
          rd_idx++;
        end
        if (bus.done === 1'b1) begin
          done_cnt++; done_cyc = cyc; done_to = bus.timeout_err;
          r1_at_done = bus.resp_r1; ext_at_done = bus.resp_ext;
        end
        if (bus.spi_valid) begin
          bus.spi_valid = 1'b0;
        end else if (busy_drv) begin
          busy_age++;
          if (valid_delay >= 0 && busy_age == valid_delay) begin
            bus.spi_valid = 1'b1; bus.spi_busy = 1'b0; busy_drv = 0; valid_cyc = cyc;
          end
        end else if (bus.spi_start === 1'b1 && start_cnt == busy_delay) begin
          bus.spi_busy = 1'b1; busy_drv = 1; busy_cyc = cyc;
        end
      end
    end
    bus.spi_busy = 1'b0; bus.spi_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b0) begin failures++;
      $display("FAIL reset_ready: got %b expected 0", bus.cmd_ready); end
    checks++; if ({bus.fifo_wr_en, bus.fifo_wr_data, bus.fifo_rd_en, bus.spi_start} !== 11'h0)
      begin failures++; $display("FAIL reset_ctl: got %h expected 0",
        {bus.fifo_wr_en, bus.fifo_wr_data, bus.fifo_rd_en, bus.spi_start}); end
    checks++; if ({bus.spi_cmd_length, bus.spi_response_length} !== 12'h0) begin failures++;
      $display("FAIL reset_len: got %h expected 0",
        {bus.spi_cmd_length, bus.spi_response_length}); end
    checks++; if ({bus.resp_r1, bus.resp_ext, bus.done, bus.timeout_err} !== {8'hFF, 34'h0})
      begin failures++; $display("FAIL reset_resp: got %h expected %h",
        {bus.resp_r1, bus.resp_ext, bus.done, bus.timeout_err}, {8'hFF, 34'h0}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++;
      $display("FAIL ready_rise: got %b expected 1", bus.cmd_ready); end
  endtask

  task automatic test_cmd0();
    run_cmd(6'd0, 32'h0, 3'd1, 3, 4, 40'h01_00000000);
    checks++; if ({wr_bytes[0], wr_bytes[1], wr_bytes[2], wr_bytes[3], wr_bytes[4], wr_bytes[5]}
      !== 48'h40_00_00_00_00_95) begin failures++; $display("FAIL cmd0_frame: got %h expected %h",
      {wr_bytes[0], wr_bytes[1], wr_bytes[2], wr_bytes[3], wr_bytes[4], wr_bytes[5]},
      48'h400000000095); end
    checks++; if (nwr !== 6 || first_wr !== 1 || last_wr !== 6) begin failures++;
      $display("FAIL cmd0_wr_timing: got n=%0d first=%0d last=%0d expected 6 1 6",
        nwr, first_wr, last_wr); end
    checks++; if (cmdlen_seen !== 6'd6 || resplen_seen !== 6'd1) begin failures++;
      $display("FAIL cmd0_lengths: got %0d %0d expected 6 1", cmdlen_seen, resplen_seen); end
    checks++; if (start_cyc !== 7 || start_cnt !== 3 || start_late !== 0) begin failures++;
      $display("FAIL cmd0_start_hold: got cyc=%0d cnt=%0d late=%0d expected 7 3 0",
        start_cyc, start_cnt, start_late); end
    checks++; if (rd_cnt !== 1 || done_cyc !== 16) begin failures++;
      $display("FAIL cmd0_drain: got rd=%0d done_cyc=%0d expected 1 16", rd_cnt, done_cyc); end
    checks++; if (r1_at_done !== 8'h01 || ext_at_done !== 32'h0 || done_to !== 1'b0) begin
      failures++; $display("FAIL cmd0_resp: got %h %h %b expected 01 00000000 0",
        r1_at_done, ext_at_done, done_to); end
    checks++; if (done_cnt !== 1 || done_after !== 1'b0 || ready_after !== 1'b1) begin
      failures++; $display("FAIL cmd0_done_pulse: got cnt=%0d after=%b ready=%b expected 1 0 1",
        done_cnt, done_after, ready_after); end
  endtask

  task automatic test_cmd8();
    run_cmd(6'd8, 32'h0000_01AA, 3'd5, 1, 2, 40'h01_00_00_01_AA);
    checks++; if ({wr_bytes[0], wr_bytes[1], wr_bytes[2], wr_bytes[3], wr_bytes[4], wr_bytes[5]}
      !== 48'h48_00_00_01_AA_87) begin failures++; $display("FAIL cmd8_frame: got %h expected %h",
      {wr_bytes[0], wr_bytes[1], wr_bytes[2], wr_bytes[3], wr_bytes[4], wr_bytes[5]},
      48'h48000001AA87); end
    checks++; if (rd_cnt !== 5 || resplen_seen !== 6'd5) begin failures++;
      $display("FAIL cmd8_rd: got rd=%0d len=%0d expected 5 5", rd_cnt, resplen_seen); end
    checks++; if (r1_at_done !== 8'h01 || ext_at_done !== 32'h0000_01AA) begin failures++;
      $display("FAIL cmd8_resp: got %h %h expected 01 000001aa", r1_at_done, ext_at_done); end
  endtask

  task automatic test_cmd55();
    run_cmd(6'd55, 32'h0, 3'd0, 2, 3, 40'h0);
    checks++; if ({wr_bytes[0], wr_bytes[1], wr_bytes[2], wr_bytes[3], wr_bytes[4], wr_bytes[5]}
      !== 48'h77_00_00_00_00_65) begin failures++; $display("FAIL cmd55_frame: got %h expected %h",
      {wr_bytes[0], wr_bytes[1], wr_bytes[2], wr_bytes[3], wr_bytes[4], wr_bytes[5]},
      48'h770000000065); end
    checks++; if (rd_cnt !== 0 || valid_cyc < 0 || done_cyc !== valid_cyc + 1) begin failures++;
      $display("FAIL cmd55_no_drain: got rd=%0d done=%0d valid=%0d expected 0 valid+1",
        rd_cnt, done_cyc, valid_cyc); end
    checks++; if (r1_at_done !== 8'hFF || done_to !== 1'b0) begin failures++;
      $display("FAIL cmd55_resp: got %h %b expected ff 0", r1_at_done, done_to); end
  endtask

  task automatic test_wait_timeout();
    run_cmd(6'd0, 32'h0, 3'd1, 2, -1, 40'h0);
    checks++; if (busy_cyc < 0 || done_cyc !== busy_cyc + 1 + 50) begin failures++;
      $display("FAIL wait_timeout_time: got done=%0d busy=%0d expected busy+51",
        done_cyc, busy_cyc); end
    checks++; if (done_to !== 1'b1 || to_after !== 1'b1 || ready_after !== 1'b1) begin
      failures++; $display("FAIL wait_timeout_flag: got %b %b ready=%b expected 1 1 1",
        done_to, to_after, ready_after); end
    checks++; if (rd_cnt !== 0 || r1_at_done !== 8'hFF) begin failures++;
      $display("FAIL wait_timeout_resp: got rd=%0d r1=%h expected 0 ff", rd_cnt, r1_at_done); end
  endtask

  task automatic test_start_timeout();
    run_cmd(6'd0, 32'h0, 3'd1, 1000, -1, 40'h0);
    checks++; if (start_cnt !== 50 || done_cyc !== 57 || done_to !== 1'b1) begin failures++;
      $display("FAIL start_timeout: got cnt=%0d done=%0d to=%b expected 50 57 1",
        start_cnt, done_cyc, done_to); end
  endtask

  task automatic test_partial();
    run_cmd(6'd55, 32'h0, 3'd3, 1, 1, 40'hAB_CD_EF_11_22);
    checks++; if (rd_cnt !== 3 || r1_at_done !== 8'hAB || ext_at_done !== 32'hCDEF_0000) begin
      failures++; $display("FAIL partial_resp: got rd=%0d %h %h expected 3 ab cdef0000",
        rd_cnt, r1_at_done, ext_at_done); end
    checks++; if (done_to !== 1'b0) begin failures++;
      $display("FAIL partial_to_clear: got %b expected 0", done_to); end
  endtask

  task automatic test_clamp();
    run_cmd(6'd58, 32'h0, 3'd7, 1, 1, 40'h00_11_22_33_44);
    checks++; if (rd_cnt !== 5 || resplen_seen !== 6'd5) begin failures++;
      $display("FAIL clamp_len: got rd=%0d len=%0d expected 5 5", rd_cnt, resplen_seen); end
    checks++; if (wr_bytes[5] !== 8'hFD || r1_at_done !== 8'h00 || ext_at_done !== 32'h11223344)
      begin failures++; $display("FAIL clamp_resp: got crc=%h %h %h expected fd 00 11223344",
        wr_bytes[5], r1_at_done, ext_at_done); end
  endtask

  task automatic test_mid_reset();
    int n;
    bit hit;
    n = 0; hit = 0;
    for (int i = 0; i < 20 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_index = 6'd17; bus.cmd_arg = 32'h1234_5678;
    bus.cmd_resp_len = 3'd1;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (bus.fifo_wr_en === 1'b1) begin
        if (n == 3) hit = 1;
        n++;
      end
    end
    checks++; if (!hit || bus.fifo_wr_data !== 8'h56) begin failures++;
      $display("FAIL midrst_k3: got hit=%b data=%h expected 1 56", hit, bus.fifo_wr_data); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.cmd_ready, bus.fifo_wr_en, bus.fifo_wr_data, bus.fifo_rd_en,
      bus.spi_start, bus.spi_cmd_length, bus.spi_response_length, bus.done, bus.timeout_err}
      !== 27'h0 || bus.resp_r1 !== 8'hFF || bus.resp_ext !== 32'h0) begin failures++;
      $display("FAIL midrst_outputs: got rdy=%b wr=%b %h clen=%0d rlen=%0d r1=%h ext=%h",
        bus.cmd_ready, bus.fifo_wr_en, bus.fifo_wr_data, bus.spi_cmd_length,
        bus.spi_response_length, bus.resp_r1, bus.resp_ext); end
    rst = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_index = 6'd17;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++; if (bus.cmd_ready !== 1'b1 || bus.fifo_wr_en !== 1'b0) begin failures++;
      $display("FAIL midrst_ignore: got ready=%b wr=%b expected 1 0",
        bus.cmd_ready, bus.fifo_wr_en); end
    @(negedge clk);
    checks++; if (bus.fifo_wr_en !== 1'b0) begin failures++;
      $display("FAIL midrst_ignore2: got wr=%b expected 0", bus.fifo_wr_en); end
    run_cmd(6'd0, 32'h0, 3'd1, 2, 2, 40'h01_00000000);
    checks++; if (wr_bytes[0] !== 8'h40 || wr_bytes[5] !== 8'h95 || r1_at_done !== 8'h01 ||
      done_to !== 1'b0) begin failures++;
      $display("FAIL midrst_recover: got %h %h r1=%h to=%b expected 40 95 01 0",
        wr_bytes[0], wr_bytes[5], r1_at_done, done_to); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_index = '0; bus.cmd_arg = '0; bus.cmd_resp_len = '0;
    bus.fifo_rd_data = 8'h00; bus.spi_busy = 1'b0; bus.spi_valid = 1'b0;
    test_reset();
    test_cmd0();
    test_cmd8();
    test_cmd55();
    test_wait_timeout();
    test_partial();
    test_start_timeout();
    test_clamp();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
